text_overlay: RTL and testbench

- Initiator/reader side of the glyph ROM interface. Converts the current VGA pixel coordinate into glyph-ROM addresses and serializes the returned 8-bit glyph rows into pixels.
- Overlays a short, runtime-writable character string onto the incoming video stream.
- Sits between the VGA timing/pixel pipeline and the display output.
- Drives the ROM address and consumes its 1-cycle registered-address read.

---
 rtl/text_overlay_pkg.sv | 11 +
 rtl/text_char_buffer.sv | 44 ++++
 rtl/text_overlay.sv | 126 ++++++++++++
 tb/tb_text_overlay.sv | 264 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/text_overlay_pkg.sv
// Shared constants and types for the text overlay: glyph geometry, ROM address
// width, the blank character code and the pixel colour type.
package text_overlay_pkg;
    typedef logic [6:0]  char_code_t;
    typedef logic [11:0] rgb444_t;

    localparam int         GLYPH_W    = 8;
    localparam int         GLYPH_H    = 16;
    localparam int         ROM_AW     = 11;
    localparam char_code_t CHAR_BLANK = 7'h20;
endpackage

// File: rtl/text_char_buffer.sv
// Double-buffered character string: writes land in the shadow copy, and the
// whole string is copied to the active copy on a frame commit pulse.
module text_char_buffer
    import text_overlay_pkg::*;
#(
    parameter int NUM_CHARS = 8
) (
    input  logic       clk,
    input  logic       reset_n,
    input  logic       wr_en,
    input  logic [3:0] wr_idx,
    input  char_code_t wr_code,
    input  logic       commit,
    input  logic [3:0] rd_idx,
    output char_code_t rd_code
);
    localparam logic [4:0] NUM_CHARS_W = 5'(NUM_CHARS);

    // Sized for the largest string so a 4-bit index never runs off the end;
    // slots at or above NUM_CHARS stay blank forever.
    char_code_t shadow [16];
    char_code_t active [16];

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            for (int i = 0; i < 16; i++) begin
                shadow[i] <= CHAR_BLANK;
                active[i] <= CHAR_BLANK;
            end
        end else begin
            // Commit reads the pre-edge shadow, so a coincident write waits a frame.
            if (commit) begin
                for (int i = 0; i < NUM_CHARS; i++) begin
                    active[i] <= shadow[i];
                end
            end
            if (wr_en && ({1'b0, wr_idx} < NUM_CHARS_W)) begin
                shadow[wr_idx] <= wr_code;
            end
        end
    end

    assign rd_code = active[rd_idx];
endmodule

// File: rtl/text_overlay.sv
// Overlays a blinking character string on a VGA pixel stream using an external
// glyph ROM with a one-cycle read; every output is the input delayed by 2 clocks.
module text_overlay
    import text_overlay_pkg::*;
#(
    parameter logic [9:0] TEXT_X       = 10'd16,
    parameter logic [9:0] TEXT_Y       = 10'd16,
    parameter int         NUM_CHARS    = 8,
    parameter int         SCALE_LOG2   = 1,
    parameter rgb444_t    FG_COLOR     = 12'hFFF,
    parameter int         BLINK_FRAMES = 32
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic [9:0]        x_pixel,
    input  logic [9:0]        y_pixel,
    input  logic              de_in,
    input  logic              h_sync_in,
    input  logic              v_sync_in,
    input  rgb444_t           rgb_in,
    input  logic              wr_en,
    input  logic [3:0]        wr_idx,
    input  char_code_t        wr_code,
    input  logic              blink_en,
    output logic [ROM_AW-1:0] rom_addr,
    input  logic [7:0]        rom_data,
    output logic              de_out,
    output logic              h_sync_out,
    output logic              v_sync_out,
    output rgb444_t           rgb_out,
    output logic              text_on
);
    localparam logic [10:0] BOX_W      = 11'(NUM_CHARS * (GLYPH_W << SCALE_LOG2));
    localparam logic [10:0] BOX_H      = 11'(GLYPH_H << SCALE_LOG2);
    localparam logic [6:0]  BLINK_LAST = 7'(BLINK_FRAMES - 1);

    logic [10:0] dx, dy;
    logic        in_box;
    logic [3:0]  char_idx, rd_idx, row;
    logic [2:0]  col;
    char_code_t  code;

    logic [2:0]  col_d1;
    logic        in_box_d1, de_d1, hs_d1, vs_d1;
    rgb444_t     rgb_d1;
    logic        vs_rise, pix;
    logic [6:0]  blink_cnt;
    logic        visible;

    // 11-bit offsets wrap to large values left of / above the box.
    always_comb begin
        dx       = {1'b0, x_pixel} - {1'b0, TEXT_X};
        dy       = {1'b0, y_pixel} - {1'b0, TEXT_Y};
        in_box   = (x_pixel >= TEXT_X) && (dx < BOX_W) &&
                   (y_pixel >= TEXT_Y) && (dy < BOX_H) && de_in;
        char_idx = 4'(dx >> (3 + SCALE_LOG2));
        col      = 3'(dx >> SCALE_LOG2);
        row      = 4'(dy >> SCALE_LOG2);
        rd_idx   = in_box ? char_idx : 4'd0;
    end

    assign vs_rise  = v_sync_in & ~vs_d1;
    assign rom_addr = {code, row};

    text_char_buffer #(.NUM_CHARS(NUM_CHARS)) u_buf (
        .clk     (clk),
        .reset_n (reset_n),
        .wr_en   (wr_en),
        .wr_idx  (wr_idx),
        .wr_code (wr_code),
        .commit  (vs_rise),
        .rd_idx  (rd_idx),
        .rd_code (code)
    );

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            blink_cnt <= '0;
            visible   <= 1'b1;
        end else if (vs_rise) begin
            if (blink_cnt == BLINK_LAST) begin
                blink_cnt <= '0;
                visible   <= ~visible;
            end else begin
                blink_cnt <= blink_cnt + 7'd1;
            end
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            col_d1    <= '0;
            in_box_d1 <= 1'b0;
            rgb_d1    <= '0;
            de_d1     <= 1'b0;
            hs_d1     <= 1'b0;
            vs_d1     <= 1'b0;
        end else begin
            col_d1    <= col;
            in_box_d1 <= in_box;
            rgb_d1    <= rgb_in;
            de_d1     <= de_in;
            hs_d1     <= h_sync_in;
            vs_d1     <= v_sync_in;
        end
    end

    // rom_data now holds the glyph row addressed during the previous cycle.
    assign pix = in_box_d1 & rom_data[3'd7 - col_d1] & (visible | ~blink_en);

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            text_on    <= 1'b0;
            rgb_out    <= '0;
            de_out     <= 1'b0;
            h_sync_out <= 1'b0;
            v_sync_out <= 1'b0;
        end else begin
            text_on    <= pix;
            rgb_out    <= pix ? FG_COLOR : rgb_d1;
            de_out     <= de_d1;
            h_sync_out <= hs_d1;
            v_sync_out <= vs_d1;
        end
    end
endmodule

// File: tb/tb_text_overlay.sv
// Directed bench for text_overlay: a glyph ROM, a frame-level model of the
// overlay checked every cycle, and literal spot checks of key pixels.
module tb_text_overlay;
    import text_overlay_pkg::*;

    localparam int          TX = 16;
    localparam int          TY = 16;
    localparam int          NC = 8;
    localparam int          S  = 1;
    localparam int          BF = 2;
    localparam logic [11:0] FG = 12'hFFF;

    logic        clk = 1'b0;
    logic        reset_n = 1'b0;
    logic [9:0]  x_pixel = '0;
    logic [9:0]  y_pixel = '0;
    logic        de_in = 1'b0;
    logic        h_sync_in = 1'b0;
    logic        v_sync_in = 1'b0;
    logic [11:0] rgb_in = '0;
    logic        wr_en = 1'b0;
    logic [3:0]  wr_idx = '0;
    logic [6:0]  wr_code = '0;
    logic        blink_en = 1'b0;
    logic [10:0] rom_addr;
    logic [7:0]  rom_data;
    logic        de_out, h_sync_out, v_sync_out, text_on;
    logic [11:0] rgb_out;

    always #5 clk = ~clk;

    text_overlay #(.BLINK_FRAMES(BF)) dut (
        .clk        (clk),
        .reset_n    (reset_n),
        .x_pixel    (x_pixel),
        .y_pixel    (y_pixel),
        .de_in      (de_in),
        .h_sync_in  (h_sync_in),
        .v_sync_in  (v_sync_in),
        .rgb_in     (rgb_in),
        .wr_en      (wr_en),
        .wr_idx     (wr_idx),
        .wr_code    (wr_code),
        .blink_en   (blink_en),
        .rom_addr   (rom_addr),
        .rom_data   (rom_data),
        .de_out     (de_out),
        .h_sync_out (h_sync_out),
        .v_sync_out (v_sync_out),
        .rgb_out    (rgb_out),
        .text_on    (text_on)
    );

    logic [7:0] rom [0:2047];
    always @(posedge clk) rom_data <= rom[rom_addr];

    int n_checks = 0;
    int n_fail = 0;
    logic [15:0] exp_q[$];

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h at %0t", name, got, exp, $time);
        end
    endtask

    // Frame-level model: string buffers, frame count, and one pixel in flight.
    logic [6:0]  m_shadow [NC];
    logic [6:0]  m_active [NC];
    int          m_frames, m_dx, m_dy, m_ch, m_col, m_row;
    logic        m_prev_vs, m_vis, m_on, m_box;
    logic [7:0]  m_glyph;
    logic        s1_fg, s1_de, s1_hs, s1_vs;
    logic [11:0] s1_rgb;

    always @(posedge clk) begin
        if (!reset_n) begin
            for (int i = 0; i < NC; i++) begin
                m_shadow[i] = 7'h20;
                m_active[i] = 7'h20;
            end
            m_frames = 0; m_prev_vs = 0;
            s1_fg = 0; s1_de = 0; s1_hs = 0; s1_vs = 0; s1_rgb = '0;
        end else begin
            m_vis = ((m_frames / BF) % 2) == 0;
            m_on  = s1_fg && (m_vis || !blink_en);
            exp_q.push_back({s1_de, s1_hs, s1_vs, m_on, m_on ? FG : s1_rgb});

            m_dx  = int'(x_pixel) - TX;
            m_dy  = int'(y_pixel) - TY;
            m_box = de_in && m_dx >= 0 && m_dx < NC * (8 << S) && m_dy >= 0 && m_dy < (16 << S);
            s1_fg = 1'b0;
            if (m_box) begin
                m_ch  = m_dx / (8 << S);
                m_col = (m_dx / (1 << S)) % 8;
                m_row = (m_dy / (1 << S)) % 16;
                check("rom_addr", rom_addr, {m_active[m_ch], 4'(m_row)});
                m_glyph = rom[int'(m_active[m_ch]) * 16 + m_row];
                s1_fg = m_glyph[7 - m_col];
            end
            s1_rgb = rgb_in; s1_de = de_in; s1_hs = h_sync_in; s1_vs = v_sync_in;

            if (v_sync_in && !m_prev_vs) begin
                for (int i = 0; i < NC; i++) m_active[i] = m_shadow[i];
                m_frames++;
            end
            if (wr_en && int'(wr_idx) < NC) m_shadow[int'(wr_idx)] = wr_code;
            m_prev_vs = v_sync_in;
        end
    end

    always @(negedge clk) begin
        if (!reset_n) begin
            exp_q.delete();
            check("reset_outputs", {de_out, h_sync_out, v_sync_out, text_on, rgb_out}, 16'h0000);
        end else if (exp_q.size() == 0) begin
            check("pipeline_empty", 32'd1, 32'd0);
        end else begin
            check("pipeline", {de_out, h_sync_out, v_sync_out, text_on, rgb_out}, exp_q.pop_front());
        end
    end

    task automatic drive(input int x, input int y, input logic de, input logic hs,
                         input logic vs, input logic [11:0] rgb);
        @(negedge clk);
        x_pixel = 10'(x); y_pixel = 10'(y);
        de_in = de; h_sync_in = hs; v_sync_in = vs; rgb_in = rgb; wr_en = 1'b0;
    endtask

    task automatic idle();
        drive(0, 0, 1'b0, 1'b0, 1'b0, 12'h000);
    endtask

    task automatic write_char(input int idx, input logic [6:0] code);
        @(negedge clk);
        de_in = 1'b0; v_sync_in = 1'b0; wr_en = 1'b1; wr_idx = 4'(idx); wr_code = code;
        idle();
    endtask

    task automatic vsync_pulse();
        drive(0, 0, 1'b0, 1'b0, 1'b1, 12'h000);
        drive(0, 0, 1'b0, 1'b0, 1'b1, 12'h000);
        idle(); idle();
    endtask

    task automatic vsync_with_write(input int idx, input logic [6:0] code);
        @(negedge clk);
        de_in = 1'b0; v_sync_in = 1'b1; wr_en = 1'b1; wr_idx = 4'(idx); wr_code = code;
        drive(0, 0, 1'b0, 1'b0, 1'b1, 12'h000);
        idle(); idle();
    endtask

    task automatic scan_row(input int y, input int x0, input int x1);
        for (int x = x0; x <= x1; x++)
            drive(x, y, (x < 640) && (y < 480), 1'b0, 1'b0, 12'(x * 7 + y * 13));
        for (int k = 0; k < 4; k++) drive(0, y, 1'b0, 1'b1, 1'b0, 12'h000);
    endtask

    task automatic px_check(input int x, input int y, input logic exp_on,
                            input logic [11:0] exp_rgb, input string name);
        drive(x, y, 1'b1, 1'b0, 1'b0, 12'h123);
        idle();
        @(negedge clk);
        check({name, "_on"}, text_on, exp_on);
        check({name, "_rgb"}, rgb_out, exp_rgb);
    endtask

    task automatic do_reset();
        @(negedge clk);
        #2 reset_n = 1'b0;
        de_in = 1'b0; v_sync_in = 1'b0; h_sync_in = 1'b0; wr_en = 1'b0; rgb_in = '0;
        repeat (2) @(negedge clk);
        #2 reset_n = 1'b1;
    endtask

    initial begin
        for (int a = 0; a < 2048; a++)
            rom[a] = ((a >> 4) == 'h20) ? 8'h00 : 8'(a * 37 + 11);
        rom['h302] = 8'h38;

        // Reset: combinational ROM address points at the blank glyph
        repeat (3) @(negedge clk);
        x_pixel = 10'd20; y_pixel = 10'd20; de_in = 1'b1;
        #1 check("reset_rom_addr", rom_addr, 11'h202);
        de_in = 1'b0;
        #1 reset_n = 1'b1;

        // Blank string: every sampled line passes the source through
        for (int y = 0; y < 480; y += 16) scan_row(y, 0, 639);
        vsync_pulse();

        // Slot 0 = '0': (20,20) is row 2 col 2 of glyph 0x38
        write_char(0, 7'h30);
        vsync_pulse();
        px_check(20, 20, 1'b1, FG, "glyph_set_bit");
        px_check(16, 20, 1'b0, 12'h123, "glyph_clear_bit");
        for (int y = 16; y < 48; y++) scan_row(y, 0, 159);

        // Mid-frame write stays hidden until the next frame commit
        scan_row(20, 0, 159);
        write_char(3, 7'h41);
        px_check(64, 20, 1'b0, 12'h123, "midframe_write_hidden");
        vsync_pulse();
        px_check(64, 20, 1'b1, FG, "committed_write");

        // Write on the vsync edge itself is deferred one frame
        vsync_with_write(4, 7'h41);
        px_check(80, 20, 1'b0, 12'h123, "edge_write_deferred");
        vsync_pulse();
        px_check(80, 20, 1'b1, FG, "edge_write_next_frame");

        // Out-of-range slot and exclusive right edge
        write_char(9, 7'h41);
        vsync_pulse();
        px_check(32, 20, 1'b0, 12'h123, "idx9_ignored");
        px_check(144, 20, 1'b0, 12'h123, "right_edge");
        scan_row(20, 0, 159);

        // Blink with two frames per half period
        do_reset();
        blink_en = 1'b1;
        write_char(0, 7'h30);
        vsync_pulse();
        px_check(20, 20, 1'b1, FG, "blink_frame1");
        vsync_pulse();
        px_check(20, 20, 1'b0, 12'h123, "blink_frame2");
        scan_row(20, 0, 159);
        vsync_pulse();
        px_check(20, 20, 1'b0, 12'h123, "blink_frame3");
        @(negedge clk) blink_en = 1'b0;
        px_check(20, 20, 1'b1, FG, "blink_disabled");
        @(negedge clk) blink_en = 1'b1;
        vsync_pulse();
        px_check(20, 20, 1'b1, FG, "blink_frame4");
        scan_row(21, 0, 159);
        vsync_pulse();
        px_check(20, 20, 1'b1, FG, "blink_frame5");

        // Asynchronous reset while a glyph pixel is on the output
        blink_en = 1'b0;
        drive(20, 20, 1'b1, 1'b0, 1'b0, 12'h123);
        idle();
        @(negedge clk);
        check("pre_reset_on", text_on, 1'b1);
        #2 reset_n = 1'b0;
        #1 check("async_clear", {de_out, h_sync_out, v_sync_out, text_on, rgb_out}, 16'h0000);
        @(negedge clk);
        x_pixel = 10'd20; y_pixel = 10'd20; de_in = 1'b1; rgb_in = 12'h456;
        #2 reset_n = 1'b1;
        @(negedge clk);
        check("release_cycle1_rgb", rgb_out, 12'h000);
        check("release_cycle1_de", de_out, 1'b0);
        de_in = 1'b0; rgb_in = 12'h000;
        @(negedge clk);
        check("release_cycle2_rgb", rgb_out, 12'h456);
        check("release_cycle2_on", text_on, 1'b0);
        repeat (4) idle();

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
